// File: rtl/mvm_stream_host_if.sv
// mvm_stream_host_if
//   Stream handshake bundle between the host engine and a layer block.
//   m_*  : host -> layer element stream (host is the transmitter)
//   s_*  : layer -> host result stream  (host is the receiver)
// Modports:
//   master : host side (drives m_valid, m_data, s_ready)
//   slave  : layer side (drives m_ready, s_valid, s_data)
interface mvm_stream_host_if #(
    parameter int WIDTH = 16
);
    logic                    m_valid;
    logic                    m_ready;
    logic signed [WIDTH-1:0] m_data;
    logic                    s_valid;
    logic                    s_ready;
    logic signed [WIDTH-1:0] s_data;

    modport master (
        output m_valid, m_data, s_ready,
        input  m_ready, s_valid, s_data
    );

    modport slave (
        input  m_valid, m_data, s_ready,
        output m_ready, s_valid, s_data
    );
endinterface

// File: rtl/mvm_stream_host.sv
// mvm_stream_host
//   Host-side stream engine for a layer block. Holds NUM_VEC input vectors of
//   N elements, streams each vector element by element into the layer, then
//   collects M results per vector into a result buffer for readback.
// Ports:
//   clk, reset        : rising-edge clock, asynchronous active-high reset
//   wr_en/addr/data   : input-buffer write port (ignored while busy)
//   start, num_vec    : launch a run of num_vec vectors (clamped to NUM_VEC)
//   strm (master)     : element stream out (m_*), result stream in (s_*)
//   rd_addr, rd_data  : result-buffer read, 1-cycle registered
//   busy, done        : run in progress / one-cycle end-of-run pulse
module mvm_stream_host #(
    parameter int N       = 8,
    parameter int M       = 4,
    parameter int WIDTH   = 16,
    parameter int NUM_VEC = 4,
    localparam int IAW    = (NUM_VEC * N > 1) ? $clog2(NUM_VEC * N) : 1,
    localparam int RAW    = (NUM_VEC * M > 1) ? $clog2(NUM_VEC * M) : 1,
    localparam int NVW    = $clog2(NUM_VEC) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [IAW-1:0]          wr_addr,
    input  logic signed [WIDTH-1:0] wr_data,
    input  logic                    start,
    input  logic [NVW-1:0]          num_vec,
    mvm_stream_host_if.master       strm,
    input  logic [RAW-1:0]          rd_addr,
    output logic signed [WIDTH-1:0] rd_data,
    output logic                    busy,
    output logic                    done
);
    localparam int VW = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
    localparam int EW = (N > 1) ? $clog2(N) : 1;
    localparam int RW = (M > 1) ? $clog2(M) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] RECV = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]     state;
    logic [VW-1:0]  vec;
    logic [EW-1:0]  elem;
    logic [RW-1:0]  res;
    logic [NVW-1:0] nv;

    logic signed [WIDTH-1:0] inbuf  [NUM_VEC*N];
    logic signed [WIDTH-1:0] resbuf [NUM_VEC*M];

    logic [NVW-1:0] nv_clamped;
    logic [IAW-1:0] in_ptr;
    logic [RAW-1:0] res_ptr;
    logic           m_fire, s_fire;
    logic           elem_last, res_last, vec_last;

    assign nv_clamped = (num_vec > NVW'(NUM_VEC)) ? NVW'(NUM_VEC) : num_vec;
    assign in_ptr     = IAW'(vec) * IAW'(N) + IAW'(elem);
    assign res_ptr    = RAW'(vec) * RAW'(M) + RAW'(res);

    // Outputs decode straight from the state register, so m_valid never
    // looks at m_ready and m_data only moves when the pointer does.
    assign strm.m_valid = (state == SEND);
    assign strm.s_ready = (state == RECV);
    assign strm.m_data  = inbuf[in_ptr];
    assign busy         = (state != IDLE);
    assign done         = (state == DONE);

    assign m_fire    = (state == SEND) && strm.m_ready;
    assign s_fire    = (state == RECV) && strm.s_valid;
    assign elem_last = (elem == EW'(N - 1));
    assign res_last  = (res == RW'(M - 1));
    assign vec_last  = (NVW'(vec) == nv - NVW'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            vec   <= '0;
            elem  <= '0;
            res   <= '0;
            nv    <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    nv    <= nv_clamped;
                    vec   <= '0;
                    elem  <= '0;
                    res   <= '0;
                    state <= (nv_clamped == '0) ? DONE : SEND;
                end
                SEND: if (m_fire) begin
                    if (elem_last) begin
                        elem  <= '0;
                        res   <= '0;
                        state <= RECV;
                    end else begin
                        elem <= elem + EW'(1);
                    end
                end
                RECV: if (s_fire) begin
                    if (res_last) begin
                        res <= '0;
                        if (vec_last) begin
                            state <= DONE;
                        end else begin
                            vec   <= vec + VW'(1);
                            elem  <= '0;
                            state <= SEND;
                        end
                    end else begin
                        res <= res + RW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Buffers carry no reset; their contents survive an aborted run.
    always_ff @(posedge clk) begin
        if (wr_en && !busy)
            inbuf[wr_addr] <= wr_data;
        if (s_fire)
            resbuf[res_ptr] <= strm.s_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rd_data <= '0;
        else
            rd_data <= resbuf[rd_addr];
    end
endmodule

// File: doc/mvm_stream_host.md
# mvm_stream_host

Host-side stream engine for the layer blocks (for example the 4-output, 8-input, 16-bit layer). It holds a buffer of input vectors and streams them one element at a time into the layer's slave port. It then collects the layer's outputs from the layer's master port and stores them in a result buffer for readback. It is the other end of both layer handshakes: it transmits on the layer's input side and receives on its output side.

## Interface
Parameters:
- N, 8: elements per input vector.
- M, 4: outputs per vector.
- WIDTH, 16: signed data width.
- NUM_VEC, 4: vector slots in the input buffer; the result buffer holds NUM_VEC*M words.

Ports:
- clk  input  1  single clock, rising-edge.
- reset  input  1  asynchronous, active-high.
- wr_en  input  1  write one input-buffer word.
- wr_addr  input  log2(NUM_VEC*N)  input-buffer word address.
- wr_data  input  WIDTH  input-buffer word.
- start  input  1  begin a run.
- num_vec  input  log2(NUM_VEC)+1  number of vectors in the run.
- m_valid  output  1  element valid toward the layer (layer s_valid).
- m_ready  input  1  layer accepts the element (layer s_ready).
- m_data  output  WIDTH signed  element toward the layer (layer data_in).
- s_valid  input  1  layer result valid (layer m_valid).
- s_ready  output  1  host accepts the result (layer m_ready).
- s_data  input  WIDTH signed  layer result (layer data_out).
- rd_addr  input  log2(NUM_VEC*M)  result-buffer read address.
- rd_data  output  WIDTH signed  result word, 1-cycle registered read.
- busy  output  1  run in progress.
- done  output  1  one-cycle pulse at end of run.

## Operation
- Buffers:
  - Input buffer is a register array, NUM_VEC*N words. Vector v, element i lives at v*N+i.
  - Result buffer: result j of vector v is stored at v*M+j.
  - Neither buffer is cleared by reset.
- Host writes:
  - wr_en is honoured only while busy=0. A write while busy=1 is dropped.
- Run control:
  - start is sampled only in IDLE. start during a run is ignored.
  - num_vec is latched at start. Values greater than NUM_VEC are clamped to NUM_VEC.
- Transfer rule, both ports: a word moves on a rising edge where valid=1 and ready=1.
  - m_valid never depends combinationally on m_ready.
  - While m_valid=1 and m_ready=0, m_data is held stable.
- States and transitions:
  - IDLE: busy=0, m_valid=0, s_ready=0. start → SEND with vec=0, elem=0. If the latched num_vec is 0, go to DONE instead.
  - SEND: m_valid=1, m_data = inbuf[vec*N+elem], combinational from the registered pointer. Each transfer increments elem. The transfer with elem=N-1 → RECV with res=0.
  - RECV: s_ready=1. Each transfer writes s_data to resbuf[vec*M+res] and increments res.
    - The transfer with res=M-1 → DONE if vec = num_vec-1.
    - Otherwise → SEND with vec+1 and elem=0.
  - DONE: done=1 for exactly one cycle, busy still 1 → IDLE.
- The host never asserts m_valid and s_ready in the same cycle.
- s_valid arriving outside RECV is not consumed (s_ready=0).
- Counters elem, res and vec wrap only through the state transitions above and never exceed N-1, M-1 and NUM_VEC-1.
- Widths: data is stored and forwarded unmodified (WIDTH-bit signed, no saturation or extension).

## Timing
- Reset values, asynchronous: state=IDLE, counters=0, m_valid=0, s_ready=0, busy=0, done=0, rd_data=0.
- Reset asserted mid-run aborts immediately. Partially written results remain in the result buffer.
- start high in IDLE at edge t:
  - busy=1 and m_valid=1 with element 0 from edge t onward.
  - The first transfer can occur at edge t+1.
- Back-to-back elements: with m_ready held high, one element transfers per cycle.
- Last element (N-1) transfers at edge e: m_valid=0 and s_ready=1 from edge e.
- Last result of a non-final vector transfers at edge r: s_ready=0 and m_valid=1 from edge r.
- Last result of the final vector transfers at edge r:
  - done=1 during cycle r..r+1.
  - busy=0 from edge r+1.
  - The result is readable at edge r+1.
- Minimum run time for num_vec=V with no stalls: V*(N+M)+1 cycles from start to done.
- Readback: rd_data = resbuf[rd_addr] registered on each edge, 1-cycle latency, valid in any state.

## Test plan
- Standalone run, ideal responder: write inbuf[0..7]=1..8, start with num_vec=1, hold m_ready=1, return results 10,20,30,40 with s_valid=1.
  - m_data sequence must be 1..8 on consecutive cycles.
  - done must fire 13 cycles after start.
  - rd_addr 0..3 must read back 10,20,30,40.
- Backpressure: m_ready toggles 1,0,0,1 and s_valid is gapped.
  - m_data must hold during stalls.
  - No element may be duplicated or skipped.
  - Results must be stored in order.
- Integration with the 4-output, 8-input layer: x = all zeros, num_vec=1. Results must be 118,65,90,0 (bias values after ReLU).
- Multi-vector: num_vec=3 with distinct vectors.
  - Results must fill addresses 0..11 in order.
  - done must pulse once.
  - start pulsed mid-run must be ignored, as must wr_en mid-run (inbuf unchanged afterwards).
- num_vec=0: done must pulse on the cycle after start, with no m_valid activity.
- Reset asserted in the middle of RECV: m_valid, s_ready, busy and done must be 0 immediately; the next run must complete normally.
